// File: rtl/display_pkg.sv
// Shared constants and types for the 7-digit multiplexed display bus.
package display_pkg;

    localparam int NUM_DIGITS = 7;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low one-hot strobe patterns; digit 0 drives strobe bit 6 low
    localparam logic [6:0] DIG0 = 7'b0111111;
    localparam logic [6:0] DIG1 = 7'b1011111;
    localparam logic [6:0] DIG2 = 7'b1101111;
    localparam logic [6:0] DIG3 = 7'b1110111;
    localparam logic [6:0] DIG4 = 7'b1111011;
    localparam logic [6:0] DIG5 = 7'b1111101;
    localparam logic [6:0] DIG6 = 7'b1111110;

    // Timing shared with the effect blocks that drive the bus
    localparam int SCAN_DWELL             = 25000;
    localparam int SETTLE_CYCLES_DEFAULT  = 4;
    localparam int TIMEOUT_CYCLES_DEFAULT = 100000;

    typedef struct packed {
        logic       valid;  // exactly one strobe bit low
        logic       idle;   // all strobe bits high
        logic       err;    // two or more strobe bits low
        logic [2:0] idx;    // digit index, meaningful only when valid
    } trans_dec_t;

    // Digit expected after d in a normal left-to-right scan
    function automatic logic [2:0] next_digit(input logic [2:0] d);
        return (d >= 3'(NUM_DIGITS - 1)) ? 3'd0 : d + 3'd1;
    endfunction

endpackage

// File: rtl/scan_capture_if.sv
// Display bus plus frame-buffer readback signals of the scan capture block.
interface scan_capture_if;
    logic [6:0]  trans_in;
    logic [6:0]  seg_in;
    logic [2:0]  rd_addr;
    logic [6:0]  rd_seg;
    logic        frame_valid;
    logic        frame_changed;
    logic        digit_err;
    logic        scan_stall;
    logic [15:0] frame_count;

    // Side that drives the display and reads frames back
    modport master (
        output trans_in, seg_in, rd_addr,
        input  rd_seg, frame_valid, frame_changed, digit_err, scan_stall, frame_count
    );

    // Capture block
    modport slave (
        input  trans_in, seg_in, rd_addr,
        output rd_seg, frame_valid, frame_changed, digit_err, scan_stall, frame_count
    );
endinterface

// File: rtl/trans_decode.sv
// Combinational decode of the active-low digit strobe into valid/idle/error and digit index.
module trans_decode
    import display_pkg::*;
(
    input  logic [6:0] trans,
    output trans_dec_t dec
);

    logic [6:0] low;
    logic       one_low;

    assign low     = ~trans;
    assign one_low = (low != 7'd0) && ((low & (low - 7'd1)) == 7'd0);

    // Classify the strobe and map the low bit position so bit 6 is digit 0
    always_comb begin
        dec.valid = one_low;
        dec.idle  = (low == 7'd0);
        dec.err   = !one_low && (low != 7'd0);
        dec.idx   = 3'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (low[i]) begin
                dec.idx = 3'(NUM_DIGITS - 1 - i);
            end
        end
    end

endmodule

// File: rtl/scan_capture.sv
// Receives the multiplexed display bus, samples each digit once per dwell and
// commits complete in-order scans into a readable 7-entry frame buffer.
module scan_capture
    import display_pkg::*;
#(
    parameter int SETTLE_CYCLES  = SETTLE_CYCLES_DEFAULT,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    scan_capture_if.slave bus
);

    localparam int DW = $clog2(TIMEOUT_CYCLES + 2);
    localparam logic [DW-1:0] SETTLE_W  = DW'(SETTLE_CYCLES);
    localparam logic [DW-1:0] TIMEOUT_W = DW'(TIMEOUT_CYCLES);
    localparam logic [DW-1:0] DWELL_MAX = DW'(TIMEOUT_CYCLES + 1);

    logic [6:0]    trans_reg;
    logic [6:0]    seg_reg;
    logic [DW-1:0] dwell_reg;
    logic [2:0]    last_digit_reg;
    logic [6:0]    seen_reg;
    logic          commit_pend_reg;
    logic [6:0]    shadow_reg [0:NUM_DIGITS-1];
    logic [6:0]    frame_reg  [0:NUM_DIGITS-1];
    logic [6:0]    rd_seg_reg;
    logic          frame_valid_reg;
    logic          frame_changed_reg;
    logic          digit_err_reg;
    logic          scan_stall_reg;
    logic [15:0]   frame_count_reg;

    trans_dec_t              dec;
    logic                    stall_now;
    logic                    sample;
    logic                    bad_strobe;
    logic                    order_ok;
    logic [6:0]              digit_bit;
    logic [6:0]              seen_upd;
    logic [NUM_DIGITS-1:0]   diff;

    trans_decode u_decode (
        .trans (trans_reg),
        .dec   (dec)
    );

    // dwell_reg counts cycles the registered strobe has held; 0 on its first cycle
    assign stall_now  = dwell_reg > TIMEOUT_W;
    assign sample     = dec.valid && (dwell_reg == SETTLE_W);
    assign bad_strobe = dec.err && (dwell_reg == '0);
    assign order_ok   = (dec.idx == next_digit(last_digit_reg));
    assign digit_bit  = 7'd1 << dec.idx;
    // An out-of-order digit restarts the scan with itself as the first entry
    assign seen_upd   = (order_ok ? seen_reg : 7'd0) | digit_bit;

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_diff
        assign diff[gi] = (frame_reg[gi] != shadow_reg[gi]);
    end

    // Register the bus once and track how long the strobe has been static
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trans_reg <= SEG_BLANK;
            seg_reg   <= SEG_BLANK;
            dwell_reg <= '0;
        end else begin
            trans_reg <= bus.trans_in;
            seg_reg   <= bus.seg_in;
            if (bus.trans_in != trans_reg) begin
                dwell_reg <= '0;
            end else if (dwell_reg != DWELL_MAX) begin
                dwell_reg <= dwell_reg + 1'b1;
            end
        end
    end

    // Sample one digit per dwell, enforce scan order and flag a completed scan
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_digit_reg  <= 3'(NUM_DIGITS - 1);
            seen_reg        <= '0;
            commit_pend_reg <= 1'b0;
            digit_err_reg   <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow_reg[i] <= SEG_BLANK;
            end
        end else begin
            digit_err_reg   <= bad_strobe || (sample && !order_ok);
            commit_pend_reg <= 1'b0;
            if (stall_now || bad_strobe) begin
                seen_reg <= '0;
            end else if (sample) begin
                shadow_reg[dec.idx] <= seg_reg;
                last_digit_reg      <= dec.idx;
                if (dec.idx == 3'(NUM_DIGITS - 1)) begin
                    commit_pend_reg <= (seen_upd == 7'h7F);
                    seen_reg        <= '0;
                end else begin
                    seen_reg <= seen_upd;
                end
            end
        end
    end

    // Copy a completed scan into the frame buffer and report it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_valid_reg   <= 1'b0;
            frame_changed_reg <= 1'b0;
            frame_count_reg   <= '0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                frame_reg[i] <= SEG_BLANK;
            end
        end else begin
            frame_valid_reg   <= commit_pend_reg;
            frame_changed_reg <= commit_pend_reg && (diff != '0);
            if (commit_pend_reg) begin
                frame_count_reg <= frame_count_reg + 16'd1;
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    frame_reg[i] <= shadow_reg[i];
                end
            end
        end
    end

    // Stall flag follows the saturated dwell counter one cycle later
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_stall_reg <= 1'b0;
        end else begin
            scan_stall_reg <= stall_now;
        end
    end

    // Registered frame read; sees the pre-commit frame when a commit lands on the same edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_seg_reg <= SEG_BLANK;
        end else begin
            rd_seg_reg <= (bus.rd_addr == 3'd7) ? SEG_BLANK : frame_reg[bus.rd_addr];
        end
    end

    assign bus.rd_seg        = rd_seg_reg;
    assign bus.frame_valid   = frame_valid_reg;
    assign bus.frame_changed = frame_changed_reg;
    assign bus.digit_err     = digit_err_reg;
    assign bus.scan_stall    = scan_stall_reg;
    assign bus.frame_count   = frame_count_reg;

endmodule
